// File: rtl/auto_parity_check.sv
// Registered even/odd parity checker for 16-bit words; mode self-selected by data_in[MODE_BIT].
// Optional saturating error counter on port err_count, enabled by defining PARITY_ERR_COUNT_EN.
module auto_parity_check #(
  parameter bit          ODD_PARITY = 1'b0,
  parameter int unsigned MODE_BIT   = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        parity_error,
  output logic        mode_16,
`ifdef PARITY_ERR_COUNT_EN
  output logic [15:0] err_count,
`endif
  output logic        check_done
);

  localparam logic [3:0] MODE_IDX = MODE_BIT[3:0];

  logic m16;
  logic err;

  logic parity_error_q, parity_error_d;
  logic mode_16_q,      mode_16_d;
  logic check_done_q,   check_done_d;

  always_comb begin
    m16 = data_in[MODE_IDX];
    err = (m16 ? (^data_in) : (^data_in[8:0])) ^ ODD_PARITY;
  end

  // data_in is only looked at when data_valid is high, so X on an idle bus never reaches the flops.
  always_comb begin
    parity_error_d = parity_error_q;
    mode_16_d      = mode_16_q;
    check_done_d   = data_valid;
    if (data_valid) begin
      parity_error_d = err;
      mode_16_d      = m16;
    end
  end

  // NOTE: state is updated with non-blocking assignments only; next-state logic lives in always_comb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_error_q <= 1'b0;
      mode_16_q      <= 1'b0;
      check_done_q   <= 1'b0;
    end else begin
      parity_error_q <= parity_error_d;
      mode_16_q      <= mode_16_d;
      check_done_q   <= check_done_d;
    end
  end

  assign parity_error = parity_error_q;
  assign mode_16      = mode_16_q;
  assign check_done   = check_done_q;

`ifdef PARITY_ERR_COUNT_EN
  logic [15:0] err_count_q, err_count_d;

  // Saturates at all-ones instead of wrapping, so a flood of errors never reads as zero.
  always_comb begin
    err_count_d = err_count_q;
    if (data_valid && err && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= 16'd0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_auto_parity_check.sv
// Self-checking bench for auto_parity_check: directed vector table, reset corner cases,
// then randomized words against a popcount-based reference model.
module tb_auto_parity_check;

  localparam int MODE_BIT = 15;
  localparam bit ODD      = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic        data_valid;
  logic        parity_error;
  logic        mode_16;
  logic        check_done;
`ifdef PARITY_ERR_COUNT_EN
  logic [15:0] err_count;
`endif

  auto_parity_check #(.ODD_PARITY(ODD), .MODE_BIT(MODE_BIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .parity_error (parity_error),
    .mode_16      (mode_16),
`ifdef PARITY_ERR_COUNT_EN
    .err_count    (err_count),
`endif
    .check_done   (check_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: parity from a population count of the checked bits.
  logic m_err, m_mode, m_done;
  int   m_cnt;

  task automatic model_reset();
    m_err = 1'b0; m_mode = 1'b0; m_done = 1'b0; m_cnt = 0;
  endtask

  task automatic model_step(input logic [15:0] d, input logic v);
    int ones;
    m_done = v;
    if (v) begin
      m_mode = d[MODE_BIT];
      ones   = m_mode ? $countones(d) : $countones(d[8:0]);
      m_err  = ((ones % 2) == 1) != ODD;
      if (m_err && m_cnt < 65535) m_cnt++;
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic        valid;
    logic        err;
    logic        mode;
    logic        done;
  } vec_t;

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{16'h0055, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{16'h01AA, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{16'h8122, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{16'h8457, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{16'hxxxx, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{16'h1234, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{16'h8001, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{16'h0055, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{16'h01AA, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{16'h8122, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{16'h7E55, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{16'h0100, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{16'h8000, 1'b1, 1'b1, 1'b1, 1'b1};

    rst_n      = 1'b0;
    data_valid = 1'b0;
    data_in    = 16'h0000;
    #20;
    check("reset_parity_error", {15'd0, parity_error}, 16'd0);
    check("reset_mode_16",      {15'd0, mode_16},      16'd0);
    check("reset_check_done",   {15'd0, check_done},   16'd0);
`ifdef PARITY_ERR_COUNT_EN
    check("reset_err_count",    err_count,             16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: inputs set on the falling edge, results checked one falling edge later.
    foreach (vecs[i]) begin
      data_in    = vecs[i].data;
      data_valid = vecs[i].valid;
      @(negedge clk);
      check($sformatf("vec%0d_parity_error", i), {15'd0, parity_error}, {15'd0, vecs[i].err});
      check($sformatf("vec%0d_mode_16", i),      {15'd0, mode_16},      {15'd0, vecs[i].mode});
      check($sformatf("vec%0d_check_done", i),   {15'd0, check_done},   {15'd0, vecs[i].done});
    end
    data_valid = 1'b0;

    // Asynchronous reset in the middle of a cycle, right after an error result.
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_parity_error", {15'd0, parity_error}, 16'd0);
    check("async_rst_mode_16",      {15'd0, mode_16},      16'd0);

    // A word presented while reset is held is lost.
    @(negedge clk);
    data_in    = 16'h81AA;
    data_valid = 1'b1;
    @(negedge clk);
    check("rst_word_lost_err",  {15'd0, parity_error}, 16'd0);
    check("rst_word_lost_done", {15'd0, check_done},   16'd0);
    check("rst_word_lost_mode", {15'd0, mode_16},      16'd0);
    data_valid = 1'b0;
    rst_n      = 1'b1;
    @(negedge clk);
    check("post_rst_idle_done", {15'd0, check_done}, 16'd0);

`ifdef PARITY_ERR_COUNT_EN
    begin
      logic [15:0] bad [3];
      bad[0] = 16'h01AA; bad[1] = 16'h8457; bad[2] = 16'h8000;
      for (int k = 0; k < 3; k++) begin
        data_in    = bad[k];
        data_valid = 1'b1;
        @(negedge clk);
      end
      data_in    = 16'h0055;
      @(negedge clk);
      data_valid = 1'b0;
      @(negedge clk);
      check("err_count_three", err_count, 16'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("err_count_cleared", err_count, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
    end
`endif

    // Randomized phase starts from a known reset state.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int r = 0; r < 400; r++) begin
      logic [15:0] d;
      logic        v;
      d = 16'($urandom);
      v = ($urandom_range(0, 3) != 0);
      data_in    = v ? d : 16'hxxxx;
      data_valid = v;
      model_step(d, v);
      @(negedge clk);
      check($sformatf("rnd%0d_parity_error", r), {15'd0, parity_error}, {15'd0, m_err});
      check($sformatf("rnd%0d_mode_16", r),      {15'd0, mode_16},      {15'd0, m_mode});
      check($sformatf("rnd%0d_check_done", r),   {15'd0, check_done},   {15'd0, m_done});
`ifdef PARITY_ERR_COUNT_EN
      check($sformatf("rnd%0d_err_count", r),    err_count,             16'(m_cnt));
`endif
    end
    data_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
